// File: rtl/lab1_imul_int_mul_param.sv
// lab1_imul_int_mul_param
//
// Iterative shift-and-add integer multiplier with a val/rdy request and
// response interface. Only one transaction is in flight at a time.
// Operands are converted to magnitudes on capture. Each CALC cycle adds one
// partial product, and the sign is applied to the full 2*NBITS product when
// the result is registered on entry to DONE.
//
// Parameters
//   NBITS       operand/result width (>= 2)
//   EARLY_TERM  1: leave CALC as soon as the remaining multiplier bits are zero
//               0: always NBITS CALC cycles
//
// Ports
//   clk       clock, all state updates on the rising edge
//   reset     synchronous active-high reset
//   req_val   request valid
//   req_rdy   request ready (high only in IDLE)
//   req_msg   {signed_mode, hi_sel, a[NBITS-1:0], b[NBITS-1:0]}
//   resp_val  response valid (high only in DONE)
//   resp_rdy  response ready
//   resp_msg  selected half of the product
module lab1_imul_int_mul_param #(
    parameter int NBITS      = 32,
    parameter bit EARLY_TERM = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_val,
    output logic               req_rdy,
    input  logic [2*NBITS+1:0] req_msg,
    output logic               resp_val,
    input  logic               resp_rdy,
    output logic [NBITS-1:0]   resp_msg
);

    localparam int CW = $clog2(NBITS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [2*NBITS-1:0] a_q;
    logic [NBITS-1:0]   b_q;
    logic [2*NBITS-1:0] acc_q;
    logic [CW-1:0]      cnt_q;
    logic               neg_q;
    logic               hi_q;
    logic [NBITS-1:0]   resp_msg_q;

    logic               msg_sm;
    logic               msg_hi;
    logic [NBITS-1:0]   msg_a;
    logic [NBITS-1:0]   msg_b;
    logic               sgn_a;
    logic               sgn_b;
    logic [NBITS-1:0]   abs_a;
    logic [NBITS-1:0]   abs_b;
    logic [2*NBITS-1:0] acc_d;
    logic [2*NBITS-1:0] prod;
    logic               last_step;

    always_comb begin
        msg_sm = req_msg[2*NBITS+1];
        msg_hi = req_msg[2*NBITS];
        msg_a  = req_msg[2*NBITS-1:NBITS];
        msg_b  = req_msg[NBITS-1:0];
        sgn_a  = msg_sm & msg_a[NBITS-1];
        sgn_b  = msg_sm & msg_b[NBITS-1];
        // Negating the most-negative value yields 2^(NBITS-1), which is the
        // correct magnitude when it is read as unsigned.
        abs_a  = sgn_a ? (~msg_a + 1'b1) : msg_a;
        abs_b  = sgn_b ? (~msg_b + 1'b1) : msg_b;

        acc_d  = b_q[0] ? (acc_q + a_q) : acc_q;
        prod   = neg_q ? (~acc_d + 1'b1) : acc_d;

        // Stop after this step if it is the last bit position, or, when early
        // termination is on, if no set multiplier bits remain above bit 0.
        last_step = (cnt_q == CW'(NBITS - 1)) ||
                    (EARLY_TERM && ((b_q >> 1) == '0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            hi_q       <= 1'b0;
            resp_msg_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_val) begin
                        a_q     <= {{NBITS{1'b0}}, abs_a};
                        b_q     <= abs_b;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        neg_q   <= sgn_a ^ sgn_b;
                        hi_q    <= msg_hi;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    a_q   <= a_q << 1;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_step) begin
                        resp_msg_q <= hi_q ? prod[2*NBITS-1:NBITS] : prod[NBITS-1:0];
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    if (resp_rdy) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_rdy  = (state_q == IDLE);
    assign resp_val = (state_q == DONE);
    assign resp_msg = resp_msg_q;

endmodule

// File: tb/tb_lab1_imul_int_mul_param.sv
// Bench for lab1_imul_int_mul_param.
// Instance 0 has fixed latency (EARLY_TERM=0).
// Instance 1 uses early termination (EARLY_TERM=1).
// Both instances use NBITS=32.
module tb_lab1_imul_int_mul_param;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        req_val;
    logic [1:0]        req_rdy;
    logic [1:0]        resp_val;
    logic [1:0]        resp_rdy;
    logic [1:0][65:0]  req_msg;
    logic [1:0][31:0]  resp_msg;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lab1_imul_int_mul_param #(.NBITS(32), .EARLY_TERM(1'b0)) dut_fix (
        .clk(clk), .reset(reset),
        .req_val(req_val[0]), .req_rdy(req_rdy[0]), .req_msg(req_msg[0]),
        .resp_val(resp_val[0]), .resp_rdy(resp_rdy[0]), .resp_msg(resp_msg[0])
    );

    lab1_imul_int_mul_param #(.NBITS(32), .EARLY_TERM(1'b1)) dut_et (
        .clk(clk), .reset(reset),
        .req_val(req_val[1]), .req_rdy(req_rdy[1]), .req_msg(req_msg[1]),
        .resp_val(resp_val[1]), .resp_rdy(resp_rdy[1]), .resp_msg(resp_msg[1])
    );

    // Reference: full-width product from plain arithmetic, then half select.
    function automatic logic [31:0] ref_mul(input logic sm, input logic hi,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        if (sm) p = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
        else    p = {32'b0, a} * {32'b0, b};
        return hi ? p[63:32] : p[31:0];
    endfunction

    // Reference latency from the request fire to resp_val.
    // This is the number of CALC cycles plus one.
    function automatic int ref_lat(input int d, input logic sm, input logic [31:0] b);
        logic [31:0] mag;
        int          top;
        mag = (sm && b[31]) ? (32'd0 - b) : b;
        if (d == 0) return 33;
        top = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) top = i + 1;
        return ((top == 0) ? 1 : top) + 1;
    endfunction

    // Issue one request and wait for its response, with resp_rdy held high.
    // The returned latency counts clock edges from the fire edge (which is
    // edge 1) to the edge after which resp_val is high. The task returns just
    // after the response-fire edge.
    task automatic run_txn(input int d, input logic sm, input logic hi,
                           input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output int lat, output bit tmo);
        int guard;
        tmo = 1'b0;
        res = '0;
        req_msg[d] = {sm, hi, a, b};
        req_val[d] = 1'b1;
        guard = 0;
        while (req_rdy[d] !== 1'b1 && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 100) tmo = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            req_val[d] = 1'b0;
        end while (resp_val[d] !== 1'b1 && lat < 100);
        if (lat >= 100) tmo = 1'b1;
        res = resp_msg[d];
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (req_rdy[d] !== 1'b1) begin
                n_fail++; $display("FAIL reset_req_rdy[%0d] got %b want 1", d, req_rdy[d]);
            end
            n_cmp++;
            if (resp_val[d] !== 1'b0) begin
                n_fail++; $display("FAIL reset_resp_val[%0d] got %b want 0", d, resp_val[d]);
            end
            n_cmp++;
            if (resp_msg[d] !== 32'h0) begin
                n_fail++; $display("FAIL reset_resp_msg[%0d] got %h want 0", d, resp_msg[d]);
            end
        end
    endtask

    task automatic test_directed();
        int          td[10]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
        logic        tsm[10] = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0};
        logic        thi[10] = '{0, 0, 1, 0, 1, 1, 0, 0, 0, 0};
        logic [31:0] ta[10]  = '{32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFD,
                                 32'h80000000, 32'h80000000, 32'h12345678, 32'd9, 32'd7};
        logic [31:0] tb[10]  = '{32'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd5,
                                 32'h80000000, 32'h80000000, 32'd0, 32'd5, 32'h80000000};
        logic [31:0] tx[10]  = '{32'h0000000C, 32'h00000001, 32'hFFFFFFFE, 32'hFFFFFFF1, 32'hFFFFFFFF,
                                 32'h40000000, 32'h00000000, 32'h00000000, 32'd45, 32'h80000000};
        int          tl[10]  = '{33, 33, 33, 33, 33, 33, 33, 2, 4, 33};
        logic [31:0] res;
        int          lat;
        bit          tmo;
        for (int i = 0; i < 10; i++) begin
            run_txn(td[i], tsm[i], thi[i], ta[i], tb[i], res, lat, tmo);
            n_cmp++;
            if (tmo || res !== tx[i]) begin
                n_fail++;
                $display("FAIL directed_result[%0d] got %h want %h (timeout=%0b)", i, res, tx[i], tmo);
            end
            n_cmp++;
            if (lat != tl[i]) begin
                n_fail++; $display("FAIL directed_latency[%0d] got %0d want %0d", i, lat, tl[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, res, exp;
        logic        sm, hi;
        int          lat, d;
        bit          tmo;
        for (int i = 0; i < 40; i++) begin
            d  = i % 2;
            a  = $urandom;
            b  = $urandom;
            sm = 1'($urandom_range(0, 1));
            hi = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: b = 32'($urandom_range(0, 255));
                1: b = 32'd0 - 32'($urandom_range(1, 100));
                default: ;
            endcase
            exp = ref_mul(sm, hi, a, b);
            run_txn(d, sm, hi, a, b, res, lat, tmo);
            n_cmp++;
            if (tmo || res !== exp) begin
                n_fail++;
                $display("FAIL random_result[%0d] d=%0d sm=%b hi=%b a=%h b=%h got %h want %h",
                         i, d, sm, hi, a, b, res, exp);
            end
            n_cmp++;
            if (lat != ref_lat(d, sm, b)) begin
                n_fail++;
                $display("FAIL random_latency[%0d] d=%0d b=%h got %0d want %0d",
                         i, d, b, lat, ref_lat(d, sm, b));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        int          guard;
        resp_rdy[1] = 1'b0;
        req_msg[1]  = {1'b1, 1'b0, 32'hFFFFFFF9, 32'd9};
        req_val[1]  = 1'b1;
        @(posedge clk); #1;
        req_val[1] = 1'b0;
        guard = 0;
        while (resp_val[1] !== 1'b1 && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        held = resp_msg[1];
        n_cmp++;
        if (guard >= 100 || held !== 32'hFFFFFFC1) begin
            n_fail++; $display("FAIL stall_result got %h want ffffffc1 (wait=%0d)", held, guard);
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (resp_msg[1] !== held || resp_val[1] !== 1'b1 || req_rdy[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d] msg=%h val=%b rdy=%b want msg=%h val=1 rdy=0",
                         c, resp_msg[1], resp_val[1], req_rdy[1], held);
            end
        end
        resp_rdy[1] = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (resp_val[1] !== 1'b0 || req_rdy[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release val=%b rdy=%b want val=0 rdy=1", resp_val[1], req_rdy[1]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        int          lat;
        bit          tmo;
        run_txn(1, 1'b0, 1'b0, 32'd11, 32'd13, res, lat, tmo);
        n_cmp++;
        if (tmo || res !== 32'd143 || req_rdy[1] !== 1'b1 || resp_val[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first got %h rdy=%b val=%b want 0000008f rdy=1 val=0",
                     res, req_rdy[1], resp_val[1]);
        end
        run_txn(1, 1'b1, 1'b1, 32'hFFFFFFFF, 32'd1, res, lat, tmo);
        n_cmp++;
        if (tmo || res !== 32'hFFFFFFFF || lat != 2) begin
            n_fail++; $display("FAIL b2b_second got %h lat=%0d want ffffffff lat=2", res, lat);
        end
    endtask

    task automatic test_reset_mid_calc();
        logic [31:0] res;
        int          lat, seen;
        bit          tmo;
        req_msg[0] = {1'b0, 1'b0, 32'd123, 32'd456};
        req_val[0] = 1'b1;
        @(posedge clk); #1;
        req_val[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_cmp++;
        if (req_rdy[0] !== 1'b1 || resp_val[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_state rdy=%b val=%b want rdy=1 val=0", req_rdy[0], resp_val[0]);
        end
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (resp_val[0] === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_fail++; $display("FAIL abort_no_resp got %0d valid cycles want 0", seen);
        end
        for (int d = 0; d < 2; d++) begin
            run_txn(d, 1'b0, 1'b0, 32'd7, 32'd6, res, lat, tmo);
            n_cmp++;
            if (tmo || res !== 32'd42) begin
                n_fail++; $display("FAIL after_abort[%0d] got %h want 0000002a", d, res);
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        req_val  = '0;
        resp_rdy = 2'b11;
        req_msg  = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_calc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
